branch_cond_unit: RTL

//  Consumer side of the flag register. Accepts conditional-branch requests from decode
//  and holds each request until the flags are stable. Evaluates the 4-bit condition

---
 rtl/branch_pkg.sv | 38 +++
 rtl/cond_eval.sv | 47 ++++
 rtl/branch_cond_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Purpose  : Condition codes, flag bit positions and FSM state encodings
//            shared by the branch condition unit.
// Revision : 1.0  initial release
// ============================================================================
package branch_pkg;

   localparam logic [3:0] COND_AL = 4'd0;
   localparam logic [3:0] COND_EQ = 4'd1;
   localparam logic [3:0] COND_NE = 4'd2;
   localparam logic [3:0] COND_CS = 4'd3;
   localparam logic [3:0] COND_CC = 4'd4;
   localparam logic [3:0] COND_MI = 4'd5;
   localparam logic [3:0] COND_PL = 4'd6;
   localparam logic [3:0] COND_VS = 4'd7;
   localparam logic [3:0] COND_VC = 4'd8;
   localparam logic [3:0] COND_GT = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_LE = 4'd12;
   localparam logic [3:0] COND_HI = 4'd13;
   localparam logic [3:0] COND_LS = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   localparam int FLAG_Z = 3;
   localparam int FLAG_S = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_EVAL = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Combinational evaluation of a 4-bit condition code against the
//            {Z,S,C,V} flags.
// Revision : 1.0  initial release
// ============================================================================
module cond_eval
   import branch_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic w_z, w_s, w_c, w_v;

   assign w_z = flags[FLAG_Z];
   assign w_s = flags[FLAG_S];
   assign w_c = flags[FLAG_C];
   assign w_v = flags[FLAG_V];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_AL: taken = 1'b1;
         COND_EQ: taken = w_z;
         COND_NE: taken = ~w_z;
         COND_CS: taken = w_c;
         COND_CC: taken = ~w_c;
         COND_MI: taken = w_s;
         COND_PL: taken = ~w_s;
         COND_VS: taken = w_v;
         COND_VC: taken = ~w_v;
         COND_GT: taken = ~w_z & (w_s == w_v);
         COND_GE: taken = (w_s == w_v);
         COND_LT: taken = (w_s != w_v);
         COND_LE: taken = w_z | (w_s != w_v);
         COND_HI: taken = w_c & ~w_z;
         COND_LS: taken = ~w_c | w_z;
         COND_NV: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_unit
// Purpose  : Holds a conditional-branch request until the flags settle, then
//            issues a one-cycle PC load. Define BR_STATS_EN for counters.
// Revision : 1.0  initial release
// ============================================================================
module branch_cond_unit
   import branch_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [3:0]      br_cond,
   input  logic [PC_W-1:0] br_target,
   input  logic [PC_W-1:0] br_pc,
   input  logic [3:0]      flag_reg,
   input  logic            alu_2_data,
   input  logic            flag_busy,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_next,
   output logic            br_taken,
   output logic            flush
`ifdef BR_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_total,
   output logic [CNT_W-1:0] stat_taken
`endif
);

   localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

   logic [1:0]      r_state, w_state_nxt;
   logic [3:0]      r_cond;
   logic [PC_W-1:0] r_target, r_fall;
   logic [PC_W-1:0] r_pc_next, w_pc_next_nxt;
   logic            r_br_taken, w_br_taken_nxt;
   logic            r_pc_load, w_pc_load_nxt;
   logic            r_flush, w_flush_nxt;
   logic            w_hazard, w_accept, w_taken;

   assign w_hazard = alu_2_data | flag_busy;
   assign w_accept = (r_state == S_IDLE) & br_valid;

   cond_eval u_cond_eval (
      .cond  (r_cond),
      .flags (flag_reg),
      .taken (w_taken)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // AL and NV do not depend on flags, so they never need to wait.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (br_valid)
                    w_state_nxt = (w_hazard && br_cond != COND_AL && br_cond != COND_NV)
                                  ? S_WAIT : S_EVAL;
         S_WAIT: if (!w_hazard) w_state_nxt = S_EVAL;
         S_EVAL: w_state_nxt = S_RESP;
         S_RESP: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_pc_next_nxt  = r_pc_next;
      w_br_taken_nxt = r_br_taken;
      w_pc_load_nxt  = 1'b0;
      w_flush_nxt    = 1'b0;
      if (r_state == S_EVAL) begin
         w_pc_next_nxt  = w_taken ? r_target : r_fall;
         w_br_taken_nxt = w_taken;
         w_pc_load_nxt  = 1'b1;
         w_flush_nxt    = w_taken;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cond     <= 4'd0;
         r_target   <= '0;
         r_fall     <= '0;
         r_pc_next  <= '0;
         r_br_taken <= 1'b0;
         r_pc_load  <= 1'b0;
         r_flush    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cond   <= br_cond;
            r_target <= br_target;
            r_fall   <= br_pc + c_pc_one;
         end
         r_pc_next  <= w_pc_next_nxt;
         r_br_taken <= w_br_taken_nxt;
         r_pc_load  <= w_pc_load_nxt;
         r_flush    <= w_flush_nxt;
      end
   end

   assign br_ready = (r_state == S_IDLE);
   assign pc_load  = r_pc_load;
   assign pc_next  = r_pc_next;
   assign br_taken = r_br_taken;
   assign flush    = r_flush;

`ifdef BR_STATS_EN
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_stat_total, r_stat_taken;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_total <= '0;
         r_stat_taken <= '0;
      end else if (r_state == S_EVAL) begin
         if (r_stat_total != '1)            r_stat_total <= r_stat_total + c_cnt_one;
         if (w_taken && r_stat_taken != '1) r_stat_taken <= r_stat_taken + c_cnt_one;
      end
   end

   assign stat_total = r_stat_total;
   assign stat_taken = r_stat_taken;
`else
   localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire
